multicycle_control_unit: RTL and testbench



---
 rtl/multicycle_control_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: steps each instruction through fetch, decode,
// execute, memory and writeback, driving the shared ALU/memory datapath strobes.
module multicycle_control_unit #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EXT_OPS  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       imm_zext,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_reg, state_next;
  state_t     decode_target;
  logic       decode_legal;
  logic       ready;
  logic [2:0] funct_alu;
  logic       funct_legal;
  logic [2:0] imm_alu;
  logic       imm_logical;

  // Without a wait handshake every memory access completes in one cycle.
  assign ready = MEM_WAIT ? mem_ready : 1'b1;
  assign state = state_reg;

  always_comb begin
    funct_alu   = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_alu     = ALU_ADD;
    imm_logical = 1'b0;
    case (op)
      OP_ANDI: begin imm_alu = ALU_AND; imm_logical = 1'b1; end
      OP_ORI:  begin imm_alu = ALU_OR;  imm_logical = 1'b1; end
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    decode_target = S_FETCH;
    decode_legal  = 1'b1;
    case (op)
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_RTYPE: begin
        if (funct_legal) decode_target = S_RTYPEEX;
        else             decode_legal  = 1'b0;
      end
      OP_BEQ:  decode_target = S_BRANCH;
      OP_BNE: begin
        if (EXT_OPS) decode_target = S_BRANCH;
        else         decode_legal  = 1'b0;
      end
      OP_ADDI: decode_target = S_IMMEX;
      OP_ANDI, OP_ORI, OP_SLTI: begin
        if (EXT_OPS) decode_target = S_IMMEX;
        else         decode_legal  = 1'b0;
      end
      OP_J:    decode_target = S_JUMP;
      default: decode_legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_next = decode_target;
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_next = S_ALUWB;
      S_IMMEX:   state_next = S_IMMWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    pc_en       = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_zext    = 1'b0;
    pc_src      = 2'b00;
    illegal_op  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        alu_src_b = 2'b01;
        IRWrite   = ready;
        pc_en     = ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~decode_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = (EXT_OPS && op == OP_BNE) ? ~zero : zero;
      end
      S_IMMEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = imm_alu;
        imm_zext    = imm_logical;
      end
      S_IMMWB: RegWrite = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: pc_en = 1'b0;
    endcase
    // No architectural write may land while reset is held.
    if (reset) begin
      pc_en    = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle stimulus and expected
// outputs are queued together, then replayed and compared cycle by cycle.
module tb_multicycle_control_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       imm_zext;
    logic [1:0] pc_src;
    logic       illegal_op;
  } obs_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] state;
    logic       ill;
  } exp2_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       imm_zext, illegal_op;
  logic [3:0] state;

  logic       n_pc_en, n_ir_write, n_iord, n_mem_write, n_reg_write, n_reg_dst, n_mem_to_reg, n_alu_src_a;
  logic [1:0] n_alu_src_b, n_pc_src;
  logic [2:0] n_alu_control;
  logic       n_imm_zext, n_illegal_op;
  logic [3:0] n_state;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  exp2_t exp2_q[$];
  obs_t  o, e;
  exp2_t e2;
  int    total, bad, cyc;

  logic [5:0] rt_funct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] rt_alu   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  logic [5:0] im_op    [4] = '{OP_ORI, OP_ANDI, OP_SLTI, OP_ADDI};
  logic [2:0] im_alu   [4] = '{3'b001, 3'b000, 3'b111, 3'b010};
  logic       im_z     [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [5:0] br_op    [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
  logic       br_zero  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       br_take  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  multicycle_control_unit #(.MEM_WAIT(1'b1), .EXT_OPS(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .IRWrite(ir_write), .IorD(iord), .MemWrite(mem_write),
    .RegWrite(reg_write), .RegDst(reg_dst), .MemtoReg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_zext(imm_zext), .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
  );

  multicycle_control_unit #(.MEM_WAIT(1'b0), .EXT_OPS(1'b0)) dut_noext (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(n_pc_en), .IRWrite(n_ir_write), .IorD(n_iord), .MemWrite(n_mem_write),
    .RegWrite(n_reg_write), .RegDst(n_reg_dst), .MemtoReg(n_mem_to_reg),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_control(n_alu_control),
    .imm_zext(n_imm_zext), .pc_src(n_pc_src), .illegal_op(n_illegal_op), .state(n_state)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input logic r, input logic [5:0] o_, input logic [5:0] f,
                               input logic z, input logic rd);
    stim_t s;
    s.rst = r; s.op = o_; s.funct = f; s.zero = z; s.rdy = rd;
    return s;
  endfunction

  function automatic obs_t base(input logic [3:0] s);
    obs_t x;
    x = '0;
    x.state = s;
    x.alu_control = 3'b010;
    return x;
  endfunction

  function automatic obs_t e_fetch(input logic rd, input logic r);
    obs_t x;
    x = base(4'd0);
    x.alu_src_b = 2'b01;
    x.pc_en = rd & ~r;
    x.ir_write = rd & ~r;
    return x;
  endfunction

  function automatic obs_t e_decode(input logic ill);
    obs_t x;
    x = base(4'd1);
    x.alu_src_b = 2'b11;
    x.illegal_op = ill;
    return x;
  endfunction

  function automatic obs_t e_memadr();
    obs_t x;
    x = base(4'd2);
    x.alu_src_a = 1'b1;
    x.alu_src_b = 2'b10;
    return x;
  endfunction

  function automatic obs_t e_memrd();
    obs_t x;
    x = base(4'd3);
    x.iord = 1'b1;
    return x;
  endfunction

  function automatic obs_t e_memwb(input logic r);
    obs_t x;
    x = base(4'd4);
    x.mem_to_reg = 1'b1;
    x.reg_write = ~r;
    return x;
  endfunction

  function automatic obs_t e_memwr(input logic r);
    obs_t x;
    x = base(4'd5);
    x.iord = 1'b1;
    x.mem_write = ~r;
    return x;
  endfunction

  function automatic obs_t e_rtypeex(input logic [2:0] alu);
    obs_t x;
    x = base(4'd6);
    x.alu_src_a = 1'b1;
    x.alu_control = alu;
    return x;
  endfunction

  function automatic obs_t e_aluwb();
    obs_t x;
    x = base(4'd7);
    x.reg_dst = 1'b1;
    x.reg_write = 1'b1;
    return x;
  endfunction

  function automatic obs_t e_branch(input logic take);
    obs_t x;
    x = base(4'd8);
    x.alu_src_a = 1'b1;
    x.alu_control = 3'b110;
    x.pc_src = 2'b01;
    x.pc_en = take;
    return x;
  endfunction

  function automatic obs_t e_immex(input logic [2:0] alu, input logic z);
    obs_t x;
    x = base(4'd9);
    x.alu_src_a = 1'b1;
    x.alu_src_b = 2'b10;
    x.alu_control = alu;
    x.imm_zext = z;
    return x;
  endfunction

  function automatic obs_t e_immwb();
    obs_t x;
    x = base(4'd10);
    x.reg_write = 1'b1;
    return x;
  endfunction

  function automatic obs_t e_jump();
    obs_t x;
    x = base(4'd11);
    x.pc_src = 2'b10;
    x.pc_en = 1'b1;
    return x;
  endfunction

  function automatic obs_t observe();
    obs_t x;
    x.state = state; x.pc_en = pc_en; x.ir_write = ir_write; x.iord = iord;
    x.mem_write = mem_write; x.reg_write = reg_write; x.reg_dst = reg_dst;
    x.mem_to_reg = mem_to_reg; x.alu_src_a = alu_src_a; x.alu_src_b = alu_src_b;
    x.alu_control = alu_control; x.imm_zext = imm_zext; x.pc_src = pc_src;
    x.illegal_op = illegal_op;
    return x;
  endfunction

  task automatic push(input stim_t s, input obs_t x);
    stim_q.push_back(s);
    exp_q.push_back(x);
  endtask

  task automatic push2(input stim_t s, input obs_t x, input exp2_t y);
    stim_q.push_back(s);
    exp_q.push_back(x);
    exp2_q.push_back(y);
  endtask

  // Inputs change on the falling edge and outputs are sampled 1 time unit later.
  task automatic drive(input stim_t s);
    @(negedge clk);
    reset = s.rst; op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
    #1;
  endtask

  task automatic test_reset();
    push(st(1'b1, OP_J, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b1));
    push(st(1'b1, OP_J, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b1));
    push(st(1'b0, OP_J, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
    push(st(1'b0, OP_J, 6'd0, 1'b0, 1'b1), e_decode(1'b0));
    push(st(1'b0, OP_J, 6'd0, 1'b0, 1'b1), e_jump());
    $display("txn reset then j");
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); o = observe(); cyc++; total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
    end
  endtask

  task automatic test_lw();
    for (int k = 0; k < 2; k++) begin
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_decode(1'b0));
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_memadr());
      if (k == 1) push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b0), e_memrd());
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_memrd());
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_memwb(1'b0));
      $display("txn lw memrd_stalls=%0d", k);
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); o = observe(); cyc++; total++;
      if (o !== e) begin
        bad++;
        $display("FAIL lw cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
    end
  endtask

  task automatic test_sw_stall();
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b1), e_decode(1'b0));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b1), e_memadr());
    for (int i = 0; i < 3; i++) push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b0), e_memwr(1'b0));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b1), e_memwr(1'b0));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0));
    $display("txn sw fetch_stalls=1 memwr_stalls=3");
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); o = observe(); cyc++; total++;
      if (o !== e) begin
        bad++;
        $display("FAIL sw_stall cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
    end
  endtask

  task automatic test_rtype();
    for (int k = 0; k < 5; k++) begin
      push(st(1'b0, OP_R, rt_funct[k], 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
      push(st(1'b0, OP_R, rt_funct[k], 1'b0, 1'b1), e_decode(1'b0));
      push(st(1'b0, OP_R, rt_funct[k], 1'b0, 1'b1), e_rtypeex(rt_alu[k]));
      push(st(1'b0, OP_R, rt_funct[k], 1'b0, 1'b1), e_aluwb());
      $display("txn rtype funct=%b", rt_funct[k]);
    end
    push(st(1'b0, OP_R, 6'b000000, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
    push(st(1'b0, OP_R, 6'b000000, 1'b0, 1'b1), e_decode(1'b1));
    push(st(1'b0, 6'b111111, 6'b100000, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
    push(st(1'b0, 6'b111111, 6'b100000, 1'b0, 1'b1), e_decode(1'b1));
    push(st(1'b0, 6'b111111, 6'b100000, 1'b0, 1'b0), e_fetch(1'b0, 1'b0));
    $display("txn illegal funct=000000 and op=111111");
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); o = observe(); cyc++; total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rtype cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 4; k++) begin
      push(st(1'b0, br_op[k], 6'd0, br_zero[k], 1'b1), e_fetch(1'b1, 1'b0));
      push(st(1'b0, br_op[k], 6'd0, br_zero[k], 1'b1), e_decode(1'b0));
      push(st(1'b0, br_op[k], 6'd0, br_zero[k], 1'b1), e_branch(br_take[k]));
      $display("txn branch op=%b zero=%b", br_op[k], br_zero[k]);
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); o = observe(); cyc++; total++;
      if (o !== e) begin
        bad++;
        $display("FAIL branch cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
    end
  endtask

  task automatic test_imm();
    for (int k = 0; k < 4; k++) begin
      push(st(1'b0, im_op[k], 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
      push(st(1'b0, im_op[k], 6'd0, 1'b0, 1'b1), e_decode(1'b0));
      push(st(1'b0, im_op[k], 6'd0, 1'b0, 1'b1), e_immex(im_alu[k], im_z[k]));
      push(st(1'b0, im_op[k], 6'd0, 1'b0, 1'b1), e_immwb());
      $display("txn imm op=%b", im_op[k]);
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); o = observe(); cyc++; total++;
      if (o !== e) begin
        bad++;
        $display("FAIL imm cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    push(st(1'b0, OP_ORI, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
    push(st(1'b0, OP_ORI, 6'd0, 1'b0, 1'b1), e_decode(1'b0));
    push(st(1'b1, OP_ORI, 6'd0, 1'b0, 1'b1), e_immex(3'b001, 1'b1));
    push(st(1'b0, OP_ORI, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0));
    push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
    push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_decode(1'b0));
    push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_memadr());
    push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_memrd());
    push(st(1'b1, OP_LW, 6'd0, 1'b0, 1'b1), e_memwb(1'b1));
    push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b1), e_decode(1'b0));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b1), e_memadr());
    push(st(1'b1, OP_SW, 6'd0, 1'b0, 1'b0), e_memwr(1'b1));
    push(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0));
    $display("txn reset during ori/lw/sw");
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); o = observe(); cyc++; total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
    end
  endtask

  // Second instance has no wait handshake and no extended opcodes; the
  // main instance is held in FETCH with mem_ready low throughout.
  task automatic test_ext_off();
    push2(st(1'b1, OP_BNE, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b1), '{1'b0, 4'd0, 1'b0});
    push2(st(1'b0, OP_BNE, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd0, 1'b0});
    push2(st(1'b0, OP_BNE, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd1, 1'b1});
    push2(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd0, 1'b0});
    push2(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd1, 1'b0});
    push2(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd2, 1'b0});
    push2(st(1'b0, OP_SW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd5, 1'b0});
    push2(st(1'b0, OP_ANDI, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd0, 1'b0});
    push2(st(1'b0, OP_ANDI, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd1, 1'b1});
    push2(st(1'b0, OP_ANDI, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0), '{1'b1, 4'd0, 1'b0});
    $display("txn noext bne, sw without wait, andi");
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); e2 = exp2_q.pop_front(); o = observe(); cyc++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL ext_off_main cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
      if (e2.vld) begin
        total++;
        if ({n_state, n_illegal_op} !== {e2.state, e2.ill}) begin
          bad++;
          $display("FAIL ext_off_noext cyc=%0d got state=%0d ill=%b exp state=%0d ill=%b", cyc, n_state, n_illegal_op, e2.state, e2.ill);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 2));
      b = int'($urandom_range(0, 3));
      for (int i = 0; i < a; i++) push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b0), e_fetch(1'b0, 1'b0));
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_fetch(1'b1, 1'b0));
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b0), e_decode(1'b0));
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b0), e_memadr());
      for (int i = 0; i < b; i++) push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b0), e_memrd());
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b1), e_memrd());
      push(st(1'b0, OP_LW, 6'd0, 1'b0, 1'b0), e_memwb(1'b0));
      push(st(1'b0, OP_J, 6'd0, 1'b1, 1'b1), e_fetch(1'b1, 1'b0));
      push(st(1'b0, OP_J, 6'd0, 1'b1, 1'b0), e_decode(1'b0));
      push(st(1'b0, OP_J, 6'd0, 1'b1, 1'b0), e_jump());
      $display("txn lw fetch_stalls=%0d memrd_stalls=%0d then j", a, b);
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front()); e = exp_q.pop_front(); o = observe(); cyc++; total++;
      if (o !== e) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got state=%0d outs=%h exp state=%0d outs=%h", cyc, o.state, o, e.state, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_branch();
    test_imm();
    test_reset_mid();
    test_ext_off();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
